// File: rtl/encoder83_pri_sync_if.sv
// Bus bundle for the registered 8-to-3 priority encoder.
//   iData  [7:0] request lines, active-low, bit 7 highest priority
//   iEI          enable input, active-low
//   oData  [2:0] inverted index of highest active request
//   oEO          enable output, active-low (enabled and idle)
//   oGS          group select, active-low (enabled and busy)
// The slave modport is the encoder side; master is the driver/consumer side.
interface encoder83_pri_sync_if;
  logic [7:0] iData;
  logic       iEI;
  logic [2:0] oData;
  logic       oEO;
  logic       oGS;

  modport slave (
    input  iData,
    input  iEI,
    output oData,
    output oEO,
    output oGS
  );

  modport master (
    output iData,
    output iEI,
    input  oData,
    input  oEO,
    input  oGS
  );
endinterface

// File: rtl/encoder83_pri_sync.sv
// 74148-style 8-to-3 priority encoder with every output registered on iClk.
// Ports:
//   iClk    system clock, rising edge
//   iReset  synchronous active-high reset; loads the disabled output state
//   bus     encoder83_pri_sync_if.slave carrying iData/iEI in, oData/oEO/oGS out
// Outputs reflect the inputs sampled at the previous rising edge. Cascade by
// feeding a higher-priority stage's oEO into the next stage's iEI.
module encoder83_pri_sync (
  input logic                  iClk,
  input logic                  iReset,
  encoder83_pri_sync_if.slave  bus
);

  logic [2:0] dataD, dataQ;
  logic       eoD, eoQ;
  logic       gsD, gsQ;

  // Next-state encode. The loop walks upward so the highest active index is
  // the last one written and therefore wins.
  always_comb begin
    dataD = 3'b111;
    eoD   = 1'b1;
    gsD   = 1'b1;
    if (!bus.iEI) begin
      if (&bus.iData) begin
        eoD = 1'b0;
      end else begin
        gsD = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (!bus.iData[k]) begin
            dataD = ~3'(k);
          end
        end
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      dataQ <= 3'b111;
      eoQ   <= 1'b1;
      gsQ   <= 1'b1;
    end else begin
      dataQ <= dataD;
      eoQ   <= eoD;
      gsQ   <= gsD;
    end
  end

  assign bus.oData = dataQ;
  assign bus.oEO   = eoQ;
  assign bus.oGS   = gsQ;

endmodule

// File: tb/tb_encoder83_pri_sync.sv
module tb_encoder83_pri_sync;

  typedef struct {
    logic [7:0] data;
    logic       ei;
    logic [2:0] expData;
    logic       expEo;
    logic       expGs;
    string      name;
  } vec_t;

  logic iClk;
  logic iReset;
  int   total;
  int   bad;

  encoder83_pri_sync_if bus ();

  encoder83_pri_sync dut (
    .iClk   (iClk),
    .iReset (iReset),
    .bus    (bus.slave)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkOut(input string name, input logic [2:0] xd, input logic xe, input logic xg);
    chk({name, ".oData"}, {5'b0, bus.oData}, {5'b0, xd});
    chk({name, ".oEO"}, {7'b0, bus.oEO}, {7'b0, xe});
    chk({name, ".oGS"}, {7'b0, bus.oGS}, {7'b0, xg});
    chk({name, ".eoGsExclusive"}, {7'b0, (bus.oEO === 1'b0) && (bus.oGS === 1'b0)}, 8'h00);
  endtask

  // Drive away from the edge, then sample just after the edge.
  task automatic step(input logic [7:0] d, input logic e, input logic r);
    @(negedge iClk);
    bus.iData = d;
    bus.iEI   = e;
    iReset    = r;
    @(posedge iClk);
    #1;
  endtask

  vec_t vecs [12];

  initial begin
    total = 0;
    bad   = 0;
    iReset    = 1'b1;
    bus.iEI   = 1'b0;
    bus.iData = 8'h00;

    vecs[0]  = '{8'hFE, 1'b1, 3'b111, 1'b1, 1'b1, "disabledFE"};
    vecs[1]  = '{8'h00, 1'b1, 3'b111, 1'b1, 1'b1, "disabled00"};
    vecs[2]  = '{8'hF6, 1'b0, 3'b100, 1'b1, 1'b0, "prioF6"};
    vecs[3]  = '{8'h00, 1'b0, 3'b000, 1'b1, 1'b0, "prio00"};
    vecs[4]  = '{8'h7F, 1'b0, 3'b000, 1'b1, 1'b0, "prio7F"};
    vecs[5]  = '{8'hFF, 1'b0, 3'b111, 1'b0, 1'b1, "noReq"};
    vecs[6]  = '{8'hFE, 1'b0, 3'b111, 1'b1, 1'b0, "onlyBit0"};
    vecs[7]  = '{8'hAA, 1'b0, 3'b001, 1'b1, 1'b0, "prioAA"};
    vecs[8]  = '{8'hDF, 1'b0, 3'b010, 1'b1, 1'b0, "prioDF"};
    vecs[9]  = '{8'hEF, 1'b0, 3'b011, 1'b1, 1'b0, "prioEF"};
    vecs[10] = '{8'hBC, 1'b0, 3'b001, 1'b1, 1'b0, "prioBC"};
    vecs[11] = '{8'hFF, 1'b1, 3'b111, 1'b1, 1'b1, "disabledFF"};

    // Reset held two edges with enabled, fully-active inputs.
    step(8'h00, 1'b0, 1'b1);
    chkOut("reset1", 3'b111, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chkOut("reset2", 3'b111, 1'b1, 1'b1);
    step(8'hFE, 1'b0, 1'b0);
    chkOut("afterReset", 3'b111, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].data, vecs[i].ei, 1'b0);
      chkOut(vecs[i].name, vecs[i].expData, vecs[i].expEo, vecs[i].expGs);
    end

    // Single-input walk with a lag check: before the edge the old code holds.
    step(8'hFF, 1'b0, 1'b0);
    chkOut("walkIdle", 3'b111, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] d;
      logic [2:0] prevExp;
      logic [2:0] curExp;
      logic       prevEo;
      logic       prevGs;
      d       = 8'hFF;
      d[k]    = 1'b0;
      curExp  = 3'(7 - k);
      prevExp = (k == 0) ? 3'b111 : 3'(8 - k);
      prevEo  = (k == 0) ? 1'b0 : 1'b1;
      prevGs  = (k == 0) ? 1'b1 : 1'b0;
      @(negedge iClk);
      bus.iData = d;
      #1;
      chkOut($sformatf("walkLag%0d", k), prevExp, prevEo, prevGs);
      @(posedge iClk);
      #1;
      chkOut($sformatf("walk%0d", k), curExp, 1'b1, 1'b0);
    end

    // Mid-stream reset discards the pending encode.
    step(8'hF6, 1'b0, 1'b0);
    chkOut("midPre", 3'b100, 1'b1, 1'b0);
    step(8'hF6, 1'b0, 1'b1);
    chkOut("midReset", 3'b111, 1'b1, 1'b1);
    step(8'hF6, 1'b0, 1'b0);
    chkOut("midRelease", 3'b100, 1'b1, 1'b0);

    // Enable toggled off while a request is active.
    step(8'h00, 1'b1, 1'b0);
    chkOut("enableOff", 3'b111, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
